// File: rtl/cpu_load_pkg.sv
// Shared load definitions: load_type_t encoding and the legal DATA_W set.
package cpu_load_pkg;

    typedef enum logic [3:0] {
        LT_W  = 4'd0,
        LT_H  = 4'd1,
        LT_HU = 4'd2,
        LT_B  = 4'd3,
        LT_BU = 4'd4,
        LT_WU = 4'd5,
        LT_D  = 4'd6,
        LT_WL = 4'd7,
        LT_WR = 4'd8
    } load_type_t;

    localparam int DATA_W_NARROW = 32;
    localparam int DATA_W_WIDE   = 64;

    function automatic bit data_w_legal(input int w);
        return (w == DATA_W_NARROW) || (w == DATA_W_WIDE);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select, sign/zero extension, unaligned merge and
// misalignment detection for one load response.
// Optional feature: LOAD_UNALIGNED_EN adds LT_WL / LT_WR (32-bit only).
module load_extract
    import cpu_load_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  addr,
    input  logic [3:0]        ltype,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] result,
    output logic              adel
);

    // Memory word shifted so the addressed byte sits in bit 0.
    logic [DATA_W-1:0] lane;
    assign lane = data >> {addr, 3'b000};

`ifdef LOAD_UNALIGNED_EN
    logic [4:0]  left_sh;
    logic [4:0]  right_sh;
    logic [31:0] left_mask;
    logic [31:0] right_mask;
    logic [31:0] merge_left;
    logic [31:0] merge_right;

    // LWL keeps the low (3-o) bytes of rt; LWR keeps its high o bytes.
    assign left_sh     = {~addr[1:0], 3'b000};
    assign right_sh    = {addr[1:0], 3'b000};
    assign left_mask   = 32'hFFFF_FFFF << left_sh;
    assign right_mask  = 32'hFFFF_FFFF >> right_sh;
    assign merge_left  = ((data[31:0] << left_sh) & left_mask) | (rt[31:0] & ~left_mask);
    assign merge_right = ((data[31:0] >> right_sh) & right_mask) | (rt[31:0] & ~right_mask);
`else
    logic unused_rt;
    assign unused_rt = ^rt;
`endif

    // Decode the load type; misaligned accesses return 0 with adel raised.
    always_comb begin
        result = '0;
        adel   = 1'b0;
        case (ltype)
            LT_B:  result = DATA_W'($signed(lane[7:0]));
            LT_BU: result = DATA_W'(lane[7:0]);
            LT_H: begin
                if (addr[0]) adel = 1'b1;
                else         result = DATA_W'($signed(lane[15:0]));
            end
            LT_HU: begin
                if (addr[0]) adel = 1'b1;
                else         result = DATA_W'(lane[15:0]);
            end
            LT_W: begin
                if (addr[1:0] != 2'b00) adel = 1'b1;
                else                    result = DATA_W'($signed(lane[31:0]));
            end
            LT_WU: begin
                if (DATA_W == DATA_W_WIDE) begin
                    if (addr[1:0] != 2'b00) adel = 1'b1;
                    else                    result = DATA_W'(lane[31:0]);
                end
            end
            LT_D: begin
                if (DATA_W == DATA_W_WIDE) begin
                    if (addr != '0) adel = 1'b1;
                    else            result = data;
                end
            end
`ifdef LOAD_UNALIGNED_EN
            LT_WL: result = DATA_W'(merge_left);
            LT_WR: result = DATA_W'(merge_right);
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/load_result_unit.sv
// Load result unit: formats data-cache responses through load_extract and
// queues them in a DEPTH-entry circular FIFO toward writeback.
// Optional feature: LOAD_UNALIGNED_EN (LT_WL / LT_WR, DATA_W=32 only).
module load_result_unit
    import cpu_load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [OFF_W-1:0]  in_addr_i,
    input  logic [3:0]        in_type_i,
    input  logic [DATA_W-1:0] in_rt_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              out_adel_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (!data_w_legal(DATA_W)) begin : g_bad_width
        $error("load_result_unit: DATA_W must be 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("load_result_unit: DEPTH must be in 1..8");
    end
`ifdef LOAD_UNALIGNED_EN
    if (DATA_W != DATA_W_NARROW) begin : g_bad_unaligned
        $error("load_result_unit: LOAD_UNALIGNED_EN requires DATA_W=32");
    end
`endif

    logic [DATA_W-1:0] ext_data;
    logic              ext_adel;

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .data   (in_data_i),
        .addr   (in_addr_i),
        .ltype  (in_type_i),
        .rt     (in_rt_i),
        .result (ext_data),
        .adel   (ext_adel)
    );

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic              mem_adel [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             live;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // live holds ready low during reset and until the first edge after it.
    assign in_ready_o  = live && (count < CNT_W'(DEPTH));
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = (count != '0);
    assign pop         = out_valid_o && out_ready_i;

    assign out_data_o  = out_valid_o ? mem_data[rd_ptr] : '0;
    assign out_tag_o   = out_valid_o ? mem_tag[rd_ptr]  : '0;
    assign out_adel_o  = out_valid_o ? mem_adel[rd_ptr] : 1'b0;

    // FIFO control: pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Entry storage; contents are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_data[wr_ptr] <= ext_data;
            mem_tag[wr_ptr]  <= in_tag_i;
            mem_adel[wr_ptr] <= ext_adel;
        end
    end

endmodule

// File: tb/tb_load_result_unit.sv
// Directed bench for load_result_unit: table of single-load vectors plus
// hand-written backpressure, flush, reset and 64-bit sequences.
module tb_load_result_unit;
    import cpu_load_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_addr = '0;
    logic [3:0]  in_type = '0;
    logic [31:0] in_rt = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_adel;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_result_unit #(.DATA_W(32), .DEPTH(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_addr_i(in_addr), .in_type_i(in_type),
        .in_rt_i(in_rt), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_tag_o(out_tag), .out_adel_o(out_adel)
    );

`ifndef LOAD_UNALIGNED_EN
    logic        v64 = 1'b0;
    logic        rdy64;
    logic [63:0] d64 = '0;
    logic [2:0]  a64 = '0;
    logic [3:0]  t64 = '0;
    logic [63:0] rt64 = '0;
    logic [4:0]  tag64 = '0;
    logic        ov64;
    logic        or64 = 1'b1;
    logic [63:0] od64;
    logic [4:0]  otag64;
    logic        oadel64;

    load_result_unit #(.DATA_W(64), .DEPTH(2), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(v64), .in_ready_o(rdy64),
        .in_data_i(d64), .in_addr_i(a64), .in_type_i(t64),
        .in_rt_i(rt64), .in_tag_i(tag64),
        .out_valid_o(ov64), .out_ready_i(or64),
        .out_data_o(od64), .out_tag_o(otag64), .out_adel_o(oadel64)
    );
`endif

    typedef struct {
        logic [3:0]  ltype;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] rt;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_adel;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] t, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] r, input logic [4:0] tg);
        @(negedge clk);
        in_type = t; in_addr = a; in_data = d; in_rt = r; in_tag = tg;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

`ifndef LOAD_UNALIGNED_EN
    task automatic send64(input logic [3:0] t, input logic [2:0] a, input logic [63:0] d,
                          input logic [4:0] tg);
        @(negedge clk);
        t64 = t; a64 = a; d64 = d; tag64 = tg;
        v64 = 1'b1;
        @(posedge clk);
        #1 v64 = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{LT_B,  2'd0, 32'h8070_F0A5, 32'h0, 5'd1,  32'hFFFF_FFA5, 1'b0};
        vecs[1]  = '{LT_BU, 2'd3, 32'h8070_F0A5, 32'h0, 5'd2,  32'h0000_0080, 1'b0};
        vecs[2]  = '{LT_H,  2'd2, 32'h8070_F0A5, 32'h0, 5'd3,  32'hFFFF_8070, 1'b0};
        vecs[3]  = '{LT_HU, 2'd2, 32'h8070_F0A5, 32'h0, 5'd4,  32'h0000_8070, 1'b0};
        vecs[4]  = '{LT_W,  2'd0, 32'h8070_F0A5, 32'h0, 5'd5,  32'h8070_F0A5, 1'b0};
        vecs[5]  = '{LT_W,  2'd2, 32'h8070_F0A5, 32'h0, 5'd7,  32'h0000_0000, 1'b1};
        vecs[6]  = '{LT_H,  2'd1, 32'h8070_F0A5, 32'h0, 5'd8,  32'h0000_0000, 1'b1};
        vecs[7]  = '{LT_B,  2'd1, 32'h8070_F0A5, 32'h0, 5'd9,  32'hFFFF_FFF0, 1'b0};
        vecs[8]  = '{LT_HU, 2'd0, 32'h8070_F0A5, 32'h0, 5'd10, 32'h0000_F0A5, 1'b0};
        vecs[9]  = '{LT_WU, 2'd0, 32'h8070_F0A5, 32'h0, 5'd11, 32'h0000_0000, 1'b0};
        vecs[10] = '{LT_D,  2'd0, 32'h8070_F0A5, 32'h0, 5'd12, 32'h0000_0000, 1'b0};
        vecs[11] = '{4'hF,  2'd0, 32'h8070_F0A5, 32'h0, 5'd13, 32'h0000_0000, 1'b0};
`ifdef LOAD_UNALIGNED_EN
        vecs[12] = '{LT_WL, 2'd1, 32'h4433_2211, 32'hAABB_CCDD, 5'd14, 32'h2211_CCDD, 1'b0};
        vecs[13] = '{LT_WR, 2'd2, 32'h4433_2211, 32'hAABB_CCDD, 5'd15, 32'hAABB_4433, 1'b0};
`else
        vecs[12] = '{LT_WL, 2'd1, 32'h4433_2211, 32'hAABB_CCDD, 5'd14, 32'h0000_0000, 1'b0};
        vecs[13] = '{LT_WR, 2'd2, 32'h4433_2211, 32'hAABB_CCDD, 5'd15, 32'h0000_0000, 1'b0};
`endif

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_adel",  64'(out_adel),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table vectors, one load at a time with the consumer always ready
        foreach (vecs[i]) begin
            send(vecs[i].ltype, vecs[i].addr, vecs[i].data, vecs[i].rt, vecs[i].tag);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
            chk($sformatf("v%0d_tag", i),   64'(out_tag),   64'(vecs[i].tag));
            chk($sformatf("v%0d_adel", i),  64'(out_adel),  64'(vecs[i].exp_adel));
            @(posedge clk);
            #1 chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
        end

        // Backpressure: fill, third push stalls, then drain in order
        out_ready = 1'b0;
        send(LT_W, 2'd0, 32'h0000_00A1, 32'h0, 5'd1);
        send(LT_W, 2'd0, 32'h0000_00B2, 32'h0, 5'd2);
        @(negedge clk);
        in_type = LT_W; in_addr = 2'd0; in_data = 32'h0000_00C3; in_tag = 5'd3;
        in_valid = 1'b1;
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head_tag",   64'(out_tag),  64'd1);
        @(posedge clk);
        #1 chk("bp_still_full", 64'(in_ready), 64'd0);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_pop1_tag",   64'(out_tag),   64'd2);
        chk("bp_pop1_data",  64'(out_data),  64'h0000_00B2);
        chk("bp_pop1_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_pop2_tag",   64'(out_tag),   64'd3);
        chk("bp_pop2_data",  64'(out_data),  64'h0000_00C3);
        @(posedge clk);
        #1;
        chk("bp_empty_valid", 64'(out_valid), 64'd0);
        chk("bp_empty_ready", 64'(in_ready),  64'd1);

        // Flush with a full buffer and a concurrent push attempt
        out_ready = 1'b0;
        send(LT_W, 2'd0, 32'h1111_1111, 32'h0, 5'd10);
        send(LT_W, 2'd0, 32'h2222_2222, 32'h0, 5'd11);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd12;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("fl_full_valid", 64'(out_valid), 64'd0);
        chk("fl_full_ready", 64'(in_ready),  64'd1);
        // Flush with one entry and an accepted-looking push
        send(LT_W, 2'd0, 32'h3333_3333, 32'h0, 5'd13);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd14; in_data = 32'h4444_4444;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("fl_push_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 chk("fl_push_dropped", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(LT_W, 2'd0, 32'h5555_5555, 32'h0, 5'd15);
        chk("fl_after_tag",  64'(out_tag),  64'd15);
        chk("fl_after_data", 64'(out_data), 64'h5555_5555);
        @(posedge clk);
        #1 chk("fl_after_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while holding one result
        out_ready = 1'b0;
        send(LT_W, 2'd0, 32'h6666_6666, 32'h0, 5'd20);
        chk("ar_before", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_tag",   64'(out_tag),   64'd0);
        chk("ar_data",  64'(out_data),  64'd0);
        chk("ar_ready", 64'(in_ready),  64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_rel_ready", 64'(in_ready),  64'd1);
        chk("ar_rel_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

`ifndef LOAD_UNALIGNED_EN
        // 64-bit word width
        send64(LT_WU, 3'd4, 64'h8000_0001_0000_0000, 5'd1);
        chk("w64_wu_data", od64, 64'h0000_0000_8000_0001);
        chk("w64_wu_adel", 64'(oadel64), 64'd0);
        send64(LT_W, 3'd4, 64'h8000_0001_0000_0000, 5'd2);
        chk("w64_w_data", od64, 64'hFFFF_FFFF_8000_0001);
        send64(LT_D, 3'd0, 64'h8000_0001_0000_0000, 5'd3);
        chk("w64_d_data", od64, 64'h8000_0001_0000_0000);
        chk("w64_d_tag",  64'(otag64), 64'd3);
        send64(LT_D, 3'd4, 64'h8000_0001_0000_0000, 5'd4);
        chk("w64_d_mis_data", od64, 64'd0);
        chk("w64_d_mis_adel", 64'(oadel64), 64'd1);
        send64(LT_WU, 3'd2, 64'h8000_0001_0000_0000, 5'd5);
        chk("w64_wu_mis_adel", 64'(oadel64), 64'd1);
        @(posedge clk);
        #1 chk("w64_empty", 64'(ov64), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
